// File: rtl/waffle_irq_pkg.sv
// Shared definitions for the WAFFLE interrupt controller.
// Register addresses, FSM encoding and the index-width helper.
package waffle_irq_pkg;

    localparam int unsigned REG_ADDR_W = 3;

    localparam logic [REG_ADDR_W-1:0] IRQ_PEND  = 3'd0;
    localparam logic [REG_ADDR_W-1:0] IRQ_MASK  = 3'd1;
    localparam logic [REG_ADDR_W-1:0] IRQ_TRIG  = 3'd2;
    localparam logic [REG_ADDR_W-1:0] IRQ_ISR   = 3'd3;
    localparam logic [REG_ADDR_W-1:0] IRQ_SWSET = 3'd4;
    localparam logic [REG_ADDR_W-1:0] IRQ_CUR   = 3'd5;

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_REQ  = 1'b1
    } irq_state_t;

    // A single source still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/waffle_irq_prio_enc.sv
// Find-first-set encoder: lowest set bit of req wins.
// Shared by the arbitration winner and the lowest in-service bit.
module waffle_irq_prio_enc
    import waffle_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid_c,
    output logic [IDX_W-1:0]   index_c
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        valid_c = 1'b0;
        index_c = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid_c = 1'b1;
                index_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/waffle_irq_ctrl.sv
// WAFFLE interrupt controller: synchronised sources, mask/trigger/pending registers,
// fixed-priority arbitration with nested in-service tracking and per-source vectors.
module waffle_irq_ctrl
    import waffle_irq_pkg::*;
#(
    parameter int unsigned       NUM_SRC    = 8,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(16'h0380),
    parameter int unsigned       VEC_STRIDE = 4,
    parameter int unsigned       ID_W       = idx_width(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    src_i,
    input  logic                  reg_we,
    input  logic                  reg_re,
    input  logic [REG_ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0]     reg_wdata,
    output logic [DATA_W-1:0]     reg_rdata,
    output logic                  irq_req,
    output logic [ID_W-1:0]       irq_id,
    output logic [ADDR_W-1:0]     irq_vec,
    input  logic                  irq_ack,
    input  logic                  irq_eoi
);

    irq_state_t state_q, state_d;

    logic [NUM_SRC-1:0] sync1_q, sync2_q, lvl_q;
    logic [NUM_SRC-1:0] pend_q, mask_q, trig_q, isr_q;
    logic [NUM_SRC-1:0] rise_c, pend_eff_c, elig_c, wdata_c;
    logic [NUM_SRC-1:0] pend_set_c, pend_clr_c, ack_mask_c, eoi_mask_c;
    logic               wr_pend_c, wr_mask_c, wr_trig_c, wr_swset_c;
    logic               ack_hit_c, load_c, win_ok_c;
    logic               win_valid_c, isr_valid_c;
    logic [ID_W-1:0]    win_idx_c, isr_idx_c;
    logic [ADDR_W-1:0]  vec_c;
    logic [DATA_W-1:0]  rd_c, cur_c;

    // Two-flop synchroniser followed by the edge-detect / level flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
            lvl_q   <= sync2_q;
        end
    end

    assign rise_c  = sync2_q & ~lvl_q;
    assign wdata_c = reg_wdata[NUM_SRC-1:0];

    assign wr_pend_c  = reg_we && (reg_addr == IRQ_PEND);
    assign wr_mask_c  = reg_we && (reg_addr == IRQ_MASK);
    assign wr_trig_c  = reg_we && (reg_addr == IRQ_TRIG);
    assign wr_swset_c = reg_we && (reg_addr == IRQ_SWSET);

    // pend_q holds latched edges for edge sources and the SWSET latch for level sources.
    assign pend_eff_c = pend_q | (~trig_q & lvl_q);
    assign elig_c     = pend_eff_c & mask_q;

    assign ack_hit_c  = (state_q == IRQ_REQ) && irq_ack;
    assign ack_mask_c = ack_hit_c ? (NUM_SRC'(1) << irq_id) : '0;
    assign eoi_mask_c = (irq_eoi && isr_valid_c) ? (NUM_SRC'(1) << isr_idx_c) : '0;

    assign pend_set_c = (rise_c & trig_q) | (wr_swset_c ? wdata_c : '0);
    assign pend_clr_c = (wr_pend_c ? wdata_c : '0) | ack_mask_c;

    waffle_irq_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(ID_W)) u_win_enc (
        .req     (elig_c),
        .valid_c (win_valid_c),
        .index_c (win_idx_c)
    );

    waffle_irq_prio_enc #(.NUM_SRC(NUM_SRC), .IDX_W(ID_W)) u_isr_enc (
        .req     (isr_q),
        .valid_c (isr_valid_c),
        .index_c (isr_idx_c)
    );

    assign win_ok_c = win_valid_c && (!isr_valid_c || (win_idx_c < isr_idx_c));
    assign vec_c    = VEC_BASE + (ADDR_W'(win_idx_c) * ADDR_W'(VEC_STRIDE));

    // Control registers; a set always beats a clear on the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            mask_q <= '0;
            trig_q <= '1;
            isr_q  <= '0;
        end else begin
            pend_q <= (pend_q & ~pend_clr_c) | pend_set_c;
            isr_q  <= (isr_q & ~eoi_mask_c) | ack_mask_c;
            if (wr_mask_c) mask_q <= wdata_c;
            if (wr_trig_c) trig_q <= wdata_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IRQ_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IRQ_IDLE: if (win_ok_c) state_d = IRQ_REQ;
            IRQ_REQ:  if (irq_ack)  state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        irq_req = (state_q == IRQ_REQ);
        load_c  = (state_q == IRQ_IDLE) && win_ok_c;
    end

    // Id and vector are frozen from the moment the request is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_id  <= '0;
            irq_vec <= '0;
        end else if (load_c) begin
            irq_id  <= win_idx_c;
            irq_vec <= vec_c;
        end
    end

    always_comb begin
        cur_c           = DATA_W'(irq_id);
        cur_c[DATA_W-1] = irq_req;
        rd_c            = '0;
        case (reg_addr)
            IRQ_PEND: rd_c = DATA_W'(pend_eff_c);
            IRQ_MASK: rd_c = DATA_W'(mask_q);
            IRQ_TRIG: rd_c = DATA_W'(trig_q);
            IRQ_ISR:  rd_c = DATA_W'(isr_q);
            IRQ_CUR:  rd_c = cur_c;
            default:  rd_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      reg_rdata <= '0;
        else if (reg_re) reg_rdata <= rd_c;
    end

endmodule

// File: tb/tb_waffle_irq_ctrl.sv
// Bench for waffle_irq_ctrl: register table, directed nesting/corner sequences,
// and randomized service rounds against a transaction-level model.
module tb_waffle_irq_ctrl;
    import waffle_irq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] src_i;
    logic       reg_we, reg_re;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata;
    logic       irq_req;
    logic [2:0] irq_id;
    logic [15:0] irq_vec;
    logic       irq_ack, irq_eoi;

    int n_chk  = 0;
    int n_fail = 0;

    waffle_irq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_i     (src_i),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .irq_req   (irq_req),
        .irq_id    (irq_id),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .irq_eoi   (irq_eoi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       do_wr;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] raddr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        reg_re = 1'b1; reg_addr = a;
        @(negedge clk);
        reg_re = 1'b0;
        d = reg_rdata;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        irq_eoi = 1'b1;
        @(negedge clk);
        irq_eoi = 1'b0;
    endtask

    task automatic pulse(input int i);
        src_i[i] = 1'b1;
        repeat (2) @(negedge clk);
        src_i[i] = 1'b0;
    endtask

    // Wait for irq_req; lat is the number of clock edges taken, -1 on timeout.
    task automatic wait_req(input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!irq_req && lat < budget);
        if (!irq_req) lat = -1;
    endtask

    task automatic no_req(input int cycles, input string name);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            seen = seen | irq_req;
        end
        chk(name, 32'(seen), 0);
    endtask

    function automatic int lowest(input logic [7:0] v);
        int r;
        r = 8;
        for (int i = 7; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int lat;
        logic [7:0] m_pend, m_mask, m_isr, m_trig;
        int w, l;
        logic done;

        tbl[0]  = '{1'b1, IRQ_MASK,  8'hA5, IRQ_MASK, 8'hA5};
        tbl[1]  = '{1'b1, IRQ_TRIG,  8'h0F, IRQ_TRIG, 8'h0F};
        tbl[2]  = '{1'b1, IRQ_MASK,  8'h00, IRQ_MASK, 8'h00};
        tbl[3]  = '{1'b1, IRQ_SWSET, 8'h81, IRQ_PEND, 8'h81};
        tbl[4]  = '{1'b1, IRQ_PEND,  8'h01, IRQ_PEND, 8'h80};
        tbl[5]  = '{1'b1, IRQ_PEND,  8'h80, IRQ_PEND, 8'h00};
        tbl[6]  = '{1'b0, 3'd0,      8'h00, 3'd6,     8'h00};
        tbl[7]  = '{1'b0, 3'd0,      8'h00, 3'd7,     8'h00};
        tbl[8]  = '{1'b0, 3'd0,      8'h00, IRQ_ISR,  8'h00};
        tbl[9]  = '{1'b0, 3'd0,      8'h00, IRQ_CUR,  8'h00};
        tbl[10] = '{1'b1, IRQ_TRIG,  8'hFF, IRQ_TRIG, 8'hFF};

        rst_n = 1'b0; src_i = '0; reg_we = 1'b0; reg_re = 1'b0; reg_addr = '0;
        reg_wdata = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(irq_req), 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_vec", 32'(irq_vec), 0);
        chk("rst_rdata", 32'(reg_rdata), 0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(IRQ_TRIG, d); chk("rst_trig", 32'(d), 32'hFF);
        rd(IRQ_MASK, d); chk("rst_mask", 32'(d), 0);
        rd(IRQ_PEND, d); chk("rst_pend", 32'(d), 0);

        // Register table
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].do_wr) wr(tbl[i].waddr, tbl[i].wdata);
            rd(tbl[i].raddr, d);
            chk($sformatf("tbl%0d", i), 32'(d), 32'(tbl[i].exp));
        end
        chk("tbl_noreq", 32'(irq_req), 0);

        // 1: edge source 2, exact latency and vector
        wr(IRQ_MASK, 8'h04);
        src_i[2] = 1'b1;
        wait_req(8, lat);
        src_i[2] = 1'b0;
        chk("t1_latency", 32'(lat), 4);
        chk("t1_id", 32'(irq_id), 2);
        chk("t1_vec", 32'(irq_vec), 32'h0388);
        rd(IRQ_CUR, d); chk("t1_cur", 32'(d), 32'h82);
        do_ack();
        chk("t1_req_drop", 32'(irq_req), 0);
        rd(IRQ_ISR, d);  chk("t1_isr", 32'(d), 32'h04);
        rd(IRQ_PEND, d); chk("t1_pend", 32'(d), 0);
        do_eoi();
        rd(IRQ_ISR, d);  chk("t1_isr_eoi", 32'(d), 0);

        // 2: nesting
        wr(IRQ_MASK, 8'h62);
        pulse(5);
        wait_req(6, lat); chk("t2_id5", 32'(irq_id), 5);
        do_ack();
        rd(IRQ_ISR, d); chk("t2_isr20", 32'(d), 32'h20);
        pulse(1);
        wait_req(6, lat); chk("t2_req1", 32'(irq_req), 1); chk("t2_id1", 32'(irq_id), 1);
        do_ack();
        rd(IRQ_ISR, d); chk("t2_isr22", 32'(d), 32'h22);
        pulse(6);
        no_req(6, "t2_blocked_a");
        do_eoi();
        no_req(4, "t2_blocked_b");
        do_eoi();
        wait_req(4, lat); chk("t2_req6", 32'(irq_req), 1);
        chk("t2_id6", 32'(irq_id), 6);
        chk("t2_vec6", 32'(irq_vec), 32'h0398);
        do_ack(); do_eoi();

        // 3: level source 3
        wr(IRQ_TRIG, 8'hF7);
        wr(IRQ_MASK, 8'h08);
        src_i[3] = 1'b1;
        wait_req(6, lat); chk("t3_req", 32'(irq_req), 1); chk("t3_id", 32'(irq_id), 3);
        do_ack();
        no_req(4, "t3_inservice");
        do_eoi();
        wait_req(4, lat); chk("t3_rereq", 32'(irq_req), 1); chk("t3_id2", 32'(irq_id), 3);
        do_ack();
        src_i[3] = 1'b0;
        repeat (5) @(negedge clk);
        do_eoi();
        no_req(4, "t3_dropped");
        rd(IRQ_PEND, d); chk("t3_pend", 32'(d), 0);
        rd(IRQ_ISR, d);  chk("t3_isr", 32'(d), 0);
        wr(IRQ_TRIG, 8'hFF);

        // 4: request frozen while mask/sources change
        wr(IRQ_MASK, 8'h11);
        pulse(4);
        wait_req(6, lat); chk("t4_id", 32'(irq_id), 4);
        wr(IRQ_MASK, 8'h00);
        pulse(0);
        repeat (3) @(negedge clk);
        chk("t4_hold_req", 32'(irq_req), 1);
        chk("t4_hold_id", 32'(irq_id), 4);
        chk("t4_hold_vec", 32'(irq_vec), 32'h0390);
        do_ack();
        no_req(5, "t4_masked");
        rd(IRQ_PEND, d); chk("t4_pend", 32'(d), 32'h01);
        wr(IRQ_PEND, 8'hFF);
        do_eoi();

        // 5: edge vs W1C on the same cycle, then SWSET of source 7
        src_i[1] = 1'b1;
        repeat (2) @(negedge clk);
        wr(IRQ_PEND, 8'h02);
        rd(IRQ_PEND, d); chk("t5_set_wins", 32'(d), 32'h02);
        src_i[1] = 1'b0;
        wr(IRQ_PEND, 8'h02);
        wr(IRQ_MASK, 8'h80);
        wr(IRQ_SWSET, 8'h80);
        wait_req(4, lat); chk("t5_req", 32'(irq_req), 1);
        chk("t5_id", 32'(irq_id), 7);
        chk("t5_vec", 32'(irq_vec), 32'h039C);
        do_ack(); do_eoi();

        // Randomized service rounds against the model
        for (int t = 0; t < 20; t++) begin
            m_mask = 8'($urandom_range(0, 255));
            m_trig = 8'($urandom_range(0, 255));
            m_pend = 8'($urandom_range(1, 255));
            m_isr  = '0;
            wr(IRQ_TRIG, m_trig);
            wr(IRQ_MASK, m_mask);
            wr(IRQ_SWSET, m_pend);
            done = 1'b0;
            for (int s = 0; s < 24; s++) begin
                if (!done) begin
                    w = lowest(m_pend & m_mask);
                    l = lowest(m_isr);
                    if (w < l) begin
                        wait_req(6, lat);
                        chk("rnd_req", 32'(irq_req), 1);
                        chk("rnd_id", 32'(irq_id), 32'(w));
                        chk("rnd_vec", 32'(irq_vec), 32'(16'h0380 + 16'(w * 4)));
                        if (m_isr != 0 && $urandom_range(0, 3) == 0) begin
                            do_eoi();
                            m_isr = m_isr & (m_isr - 8'd1);
                        end
                        do_ack();
                        m_isr  = m_isr | (8'd1 << w);
                        m_pend = m_pend & ~(8'd1 << w);
                    end else begin
                        no_req(4, "rnd_noreq");
                        if (m_isr == 0) done = 1'b1;
                        else begin
                            do_eoi();
                            m_isr = m_isr & (m_isr - 8'd1);
                        end
                    end
                    rd(IRQ_ISR, d);  chk("rnd_isr", 32'(d), 32'(m_isr));
                    rd(IRQ_PEND, d); chk("rnd_pend", 32'(d), 32'(m_pend));
                end
            end
            wr(IRQ_MASK, 8'h00);
            wr(IRQ_PEND, 8'hFF);
            repeat (8) do_eoi();
        end
        wr(IRQ_TRIG, 8'hFF);

        // 6: asynchronous reset during an active request
        wr(IRQ_TRIG, 8'h0F);
        wr(IRQ_MASK, 8'h01);
        wr(IRQ_SWSET, 8'h01);
        wait_req(6, lat); chk("t6_req_before", 32'(irq_req), 1);
        rd(IRQ_MASK, d);
        rst_n = 1'b0;
        #1;
        chk("t6_req_async", 32'(irq_req), 0);
        chk("t6_id", 32'(irq_id), 0);
        chk("t6_vec", 32'(irq_vec), 0);
        chk("t6_rdata", 32'(reg_rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(IRQ_PEND, d); chk("t6_pend", 32'(d), 0);
        rd(IRQ_MASK, d); chk("t6_mask", 32'(d), 0);
        rd(IRQ_TRIG, d); chk("t6_trig", 32'(d), 32'hFF);
        rd(IRQ_ISR, d);  chk("t6_isr", 32'(d), 0);
        no_req(3, "t6_noreq");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
